// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule definitions: controller states, round count and CK generation.
package sm4_pkg;

    localparam int unsigned SM4_ROUNDS = 32;
    localparam int unsigned RK_IDX_W   = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } sm4_state_e;

    // CK(i) byte j (j=0 is the MSB) = ((4i+j)*7) mod 256; 8-bit context gives the wrap.
    function automatic logic [31:0] sm4_ck(input logic [RK_IDX_W-1:0] round);
        logic [7:0]  base;
        logic [31:0] ck;
        base = {1'b0, round, 2'b00};
        ck   = '0;
        for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
        end
        return ck;
    endfunction

endpackage

// File: rtl/one_round_for_key_exp.sv
// One round of the SM4 key expansion; folds in FK when the round index is zero.
module one_round_for_key_exp (
    input  logic [127:0] data_in,
    input  logic [4:0]   count_round_in,
    input  logic [31:0]  ck_parameter_in,
    output logic [127:0] result_out
);

    localparam logic [127:0] Fk = 128'ha3b1bac656aa3350677d9197b27022dc;

    localparam logic [2047:0] SboxTab = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Entry 0 sits in the top byte, so the bit offset is (255 - x) * 8 = {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = ~x;
        return SboxTab[{inv, 3'b000} +: 8];
    endfunction

    logic [127:0] k;
    logic [31:0]  t_in, b, l;

    // Nonlinear tau then the key-schedule linear transform L'.
    always_comb begin
        k    = (count_round_in == 5'd0) ? (data_in ^ Fk) : data_in;
        t_in = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck_parameter_in;
        b    = {sbox(t_in[31:24]), sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0])};
        l    = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
        result_out = {k[95:0], k[127:96] ^ l};
    end

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-schedule sequencer: accepts a user key, runs 32 expansion rounds, stores and
// streams each round key, and serves indexed (optionally reversed) reads.
module sm4_key_sched_ctrl
    import sm4_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid_in,
    input  logic [127:0]        key_in,
    output logic                key_ready_out,
    output logic                busy_out,
    output logic                keys_valid_out,
    output logic                rk_valid_out,
    output logic [31:0]         rk_out,
    output logic [RK_IDX_W-1:0] rk_idx_out,
    input  logic [RK_IDX_W-1:0] rk_rd_addr_in,
    input  logic                rk_rd_dec_in,
    output logic [31:0]         rk_rd_data_out
);

    sm4_state_e          fsm_q;
    logic [RK_IDX_W-1:0] round_q;
    logic [127:0]        state_q;
    logic [31:0]         ck_param;
    logic [127:0]        result;
    logic [31:0]         rk_mem [SM4_ROUNDS];
    logic [RK_IDX_W-1:0] rd_addr;
    logic [31:0]         rd_data_q;
    logic                run;

    assign ck_param = sm4_ck(round_q);

    one_round_for_key_exp u_round (
        .data_in         (state_q),
        .count_round_in  (round_q),
        .ck_parameter_in (ck_param),
        .result_out      (result)
    );

    // Controller FSM: key capture, round counting and the running key state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= StIdle;
            round_q <= '0;
            state_q <= '0;
        end else begin
            unique case (fsm_q)
                StIdle, StDone: begin
                    if (key_valid_in) begin
                        state_q <= key_in;
                        round_q <= '0;
                        fsm_q   <= StRun;
                    end
                end
                StRun: begin
                    state_q <= result;
                    round_q <= round_q + 5'd1;
                    if (round_q == 5'(SM4_ROUNDS - 1)) begin
                        fsm_q <= StDone;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    // Round-key store; deliberately not reset, a reset edge only suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && fsm_q == StRun) begin
            rk_mem[round_q] <= result[31:0];
        end
    end

    assign rd_addr = rk_rd_dec_in ? (5'd31 - rk_rd_addr_in) : rk_rd_addr_in;

    // Registered read port for the cipher round engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rk_mem[rd_addr];
        end
    end

    assign run            = (fsm_q == StRun);
    assign key_ready_out  = !run;
    assign busy_out       = run;
    assign keys_valid_out = (fsm_q == StDone);
    assign rk_valid_out   = run;
    // Stream is forced to zero outside RUN so idle outputs match the reset values.
    assign rk_out         = run ? result[31:0] : 32'h0;
    assign rk_idx_out     = run ? round_q : '0;
    assign rk_rd_data_out = rd_data_q;

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// Scoreboard bench for sm4_key_sched_ctrl: expected round-key pulses are queued by the
// stimulus and popped by a negedge monitor; control and read-port checks are directed.
module tb_sm4_key_sched_ctrl;

    localparam logic [127:0] KeyStd = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [31:0]  Rk0    = 32'hf12186f9;
    localparam logic [31:0]  Rk31   = 32'h9124a012;

    typedef struct {
        logic [4:0]  idx;
        bit          known;
        logic [31:0] val;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         key_valid_in;
    logic [127:0] key_in;
    logic         key_ready_out;
    logic         busy_out;
    logic         keys_valid_out;
    logic         rk_valid_out;
    logic [31:0]  rk_out;
    logic [4:0]   rk_idx_out;
    logic [4:0]   rk_rd_addr_in;
    logic         rk_rd_dec_in;
    logic [31:0]  rk_rd_data_out;

    int           n_vec = 0;
    int           n_err = 0;
    exp_t         exp_q[$];
    logic [31:0]  streamed [32];

    sm4_key_sched_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid_in   (key_valid_in),
        .key_in         (key_in),
        .key_ready_out  (key_ready_out),
        .busy_out       (busy_out),
        .keys_valid_out (keys_valid_out),
        .rk_valid_out   (rk_valid_out),
        .rk_out         (rk_out),
        .rk_idx_out     (rk_idx_out),
        .rk_rd_addr_in  (rk_rd_addr_in),
        .rk_rd_dec_in   (rk_rd_dec_in),
        .rk_rd_data_out (rk_rd_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue n expected pulses with indices 0..n-1; for the standard key rk0/rk31 are known.
    task automatic push_run(input int n, input bit std);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx   = 5'(i);
            e.known = std && (i == 0 || i == 31);
            e.val   = (i == 0) ? Rk0 : Rk31;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expectation per round-key pulse and probes CK at rounds 0, 1, 31.
    always @(negedge clk) begin
        exp_t e;
        if (rk_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rk: got idx %0d value %h, expected no pulse",
                         rk_idx_out, rk_out);
            end else begin
                e = exp_q.pop_front();
                check("rk_idx", rk_idx_out, e.idx);
                if (e.known) check($sformatf("rk%0d_val", e.idx), rk_out, e.val);
            end
            streamed[rk_idx_out] = rk_out;
            case (rk_idx_out)
                5'd0:  check("ck_round0", dut.ck_param, 32'h00070e15);
                5'd1:  check("ck_round1", dut.ck_param, 32'h1c232a31);
                5'd31: check("ck_round31", dut.ck_param, 32'h646b7279);
                default: ;
            endcase
        end
    end

    // Called just after the accept edge E0; checks keys_valid timing at E31 and E32.
    task automatic wait_keys_valid(input string tag);
        repeat (31) @(posedge clk);
        #1;
        check({tag, "_kv_before_e32"}, keys_valid_out, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_kv_at_e32"}, keys_valid_out, 1'b1);
        check({tag, "_ready_done"}, key_ready_out, 1'b1);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    // Called just after E0; requires 32 consecutive pulses 0..31 with ready low throughout.
    task automatic watch_run(input string tag);
        bit ok;
        ok = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (!(rk_valid_out === 1'b1 && rk_idx_out === 5'(c) &&
                  key_ready_out === 1'b0 && busy_out === 1'b1)) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check({tag, "_run_no_gaps"}, ok, 1'b1);
    endtask

    task automatic send_key(input logic [127:0] key);
        key_in       = key;
        key_valid_in = 1'b1;
        @(posedge clk);
        #1;
        key_valid_in = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [4:0] addr, input logic dec,
                              input logic [31:0] exp);
        rk_rd_addr_in = addr;
        rk_rd_dec_in  = dec;
        @(posedge clk);
        #1;
        check(name, rk_rd_data_out, exp);
    endtask

    initial begin
        bit found;
        rst           = 1'b1;
        key_valid_in  = 1'b0;
        key_in        = '0;
        rk_rd_addr_in = '0;
        rk_rd_dec_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_key_ready", key_ready_out, 1'b1);
        check("rst_busy", busy_out, 1'b0);
        check("rst_keys_valid", keys_valid_out, 1'b0);
        check("rst_rk_valid", rk_valid_out, 1'b0);
        check("rst_rk_out", rk_out, 32'h0);
        check("rst_rk_idx", rk_idx_out, 5'd0);
        check("rst_rd_data", rk_rd_data_out, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Standard vector
        push_run(32, 1'b1);
        send_key(KeyStd);
        check("std_busy_after_accept", busy_out, 1'b1);
        wait_keys_valid("std");

        // Read port with and without address reversal
        read_check("rd_a0_enc", 5'd0, 1'b0, Rk0);
        read_check("rd_a0_dec", 5'd0, 1'b1, Rk31);
        read_check("rd_a31_dec", 5'd31, 1'b1, Rk0);
        read_check("rd_a31_enc", 5'd31, 1'b0, Rk31);

        // Back-to-back from DONE, with an all-zero key held through RUN
        push_run(32, 1'b1);
        push_run(32, 1'b0);
        key_in       = KeyStd;
        key_valid_in = 1'b1;
        @(posedge clk);
        #1;
        key_in = '0;
        watch_run("held");
        check("held_kv_first_done", keys_valid_out, 1'b1);
        check("held_ready_first_done", key_ready_out, 1'b1);
        @(posedge clk);
        #1;
        key_valid_in = 1'b0;
        check("b2b_kv_dropped", keys_valid_out, 1'b0);
        check("b2b_busy", busy_out, 1'b1);
        watch_run("zero");
        check("zero_kv", keys_valid_out, 1'b1);
        check("zero_queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 32; i++) begin
            read_check($sformatf("zero_readback_%0d", i), 5'(i), 1'b0, streamed[i]);
        end
        read_check("zero_readback_dec0", 5'd0, 1'b1, streamed[31]);

        // Reset in the middle of a run
        push_run(11, 1'b1);
        send_key(KeyStd);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (rk_valid_out === 1'b1 && rk_idx_out === 5'd10) found = 1'b1;
        end
        check("rst_round10_seen", found, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_rk_valid", rk_valid_out, 1'b0);
        check("midrst_keys_valid", keys_valid_out, 1'b0);
        check("midrst_key_ready", key_ready_out, 1'b1);
        check("midrst_busy", busy_out, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_queue_drained", exp_q.size(), 0);
        check("midrst_still_idle", keys_valid_out, 1'b0);

        // Fresh key after the abort
        push_run(32, 1'b1);
        send_key(KeyStd);
        wait_keys_valid("fresh");
        read_check("fresh_rd_a0_dec", 5'd0, 1'b1, Rk31);
        read_check("fresh_rd_a0_enc", 5'd0, 1'b0, Rk0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm4_key_sched_ctrl.md
# sm4_key_sched_ctrl

Sequencer for the SM4 key schedule. It accepts a 128-bit user key over a valid/ready handshake and drives the single-round key-expansion datapath for 32 consecutive cycles. Each round key is stored in a 32×32 register file and also streamed out as it is produced. The cipher round engine reads stored keys by round index, with address reversal for decryption.

## Interface
Parameters: none; all SM4 constants are fixed.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `key_valid_in`  in  1  user key offered
- `key_in`  in  128  user key MK0..MK3, MK0 in bits [127:96]
- `key_ready_out`  out  1  block can accept a key (IDLE or DONE)
- `busy_out`  out  1  expansion in progress
- `keys_valid_out`  out  1  all 32 round keys stored and current
- `rk_valid_out`  out  1  one-cycle pulse per round key produced
- `rk_out`  out  32  round key just produced
- `rk_idx_out`  out  5  index 0..31 of `rk_out`
- `rk_rd_addr_in`  in  5  cipher-round index to read
- `rk_rd_dec_in`  in  1  1 = decrypt; read address becomes 31 − addr
- `rk_rd_data_out`  out  32  registered read data

## Operation
- FSM states:
  - IDLE: `key_ready_out`=1. On `key_valid_in`: load `key_in` into `state_q`, set `round_q`=0, go to RUN.
  - RUN: `busy_out`=1, `key_ready_out`=0, `key_valid_in` ignored. Each cycle:
    - Drive the datapath with `data_in`=`state_q`, `count_round_in`=`round_q`, `ck_parameter_in`=CK(`round_q`).
    - `state_q` ← `result_out`; `rk[round_q]` ← `result_out[31:0]`.
    - Pulse `rk_valid_out`, with `rk_out`=`result_out[31:0]` and `rk_idx_out`=`round_q`.
    - `round_q` increments. When `round_q`=31, go to DONE.
  - DONE: `keys_valid_out`=1, `key_ready_out`=1. A new `key_valid_in` behaves as in IDLE, and `keys_valid_out` falls on the same edge.
- The datapath applies FK itself when `count_round_in`=0. The controller supplies only the raw key and the round index.
- CK(i) byte j (j=0 is MSB) = ((4i+j)·7) mod 256, computed combinationally from `round_q` using 8-bit wrap arithmetic. Example: CK(0)=00070e15, CK(31)=646b7279.
- Read port: `rk_rd_data_out` ← `rk[rk_rd_dec_in ? 31−rk_rd_addr_in : rk_rd_addr_in]`. 5-bit subtraction, no wrap issues. Reads are legal in any state. During RUN they return partially updated contents; gating on `keys_valid_out` is the consumer's duty.
- The register file is not cleared by reset. Contents are defined only after the first DONE.

## Timing
- Reset values: state IDLE, `round_q`=0, `state_q`=0, `key_ready_out`=1, `busy_out`=0, `keys_valid_out`=0, `rk_valid_out`=0, `rk_out`=0, `rk_idx_out`=0, `rk_rd_data_out`=0.
- Accept edge = E0. RUN occupies the cycles after E0 through E32.
  - rk0 pulses during the first RUN cycle and is written on E1.
  - rk31 is written on E32.
  - `keys_valid_out` is high from E32 onward.
  - Latency: 32 cycles from accept to keys valid.
- Back-to-back key from DONE: accepted on the edge where valid and ready are both high. `keys_valid_out` is low on the following cycle. RUN restarts with no bubble.
- Read latency: exactly 1 cycle, addr at edge N gives data after edge N.
- `rst` mid-RUN: the next edge forces IDLE, aborts the sequence and clears `keys_valid_out` and `rk_valid_out`. Partially written keys remain in the register file but are not flagged valid.
- `rst` has priority over `key_valid_in` on the same edge.

## Structure
- Shared package `sm4_pkg`:
  - FSM state enum (IDLE, RUN, DONE)
  - `SM4_ROUNDS`=32
  - CK generation function
  - round-key index width (5)
- One sub-module: the existing one-round key-expansion datapath `one_round_for_key_exp`, instantiated once. The controller holds only the state register, counter, register file and read mux.

## Test plan
- Standard vector: `key_in`=0123456789abcdeffedcba9876543210 → `rk_valid_out` with idx 0 gives f12186f9. Idx 31 gives 9124a012. `keys_valid_out` rises exactly 32 cycles after accept.
- Read port, same key: addr 0, dec=0 → f12186f9 one cycle later. Addr 0, dec=1 → 9124a012. Addr 31, dec=1 → f12186f9.
- Handshake: hold `key_valid_in` high through RUN with a different key. That key is ignored and `key_ready_out`=0 for all 32 RUN cycles. It is accepted on the first DONE cycle, and `keys_valid_out` drops the next cycle.
- Reset mid-run: assert `rst` at round 10 → IDLE next cycle. No `rk_valid_out`, `keys_valid_out`=0, `key_ready_out`=1. A fresh key then completes with correct rk0/rk31.
- CK check: probe `ck_parameter_in` at rounds 0, 1 and 31 → 00070e15, 1c232a31, 646b7279.
- All-zero key: 32 pulses with indices 0..31 in order, no gaps. The register-file readback of every index equals the streamed value.
